branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch/jump decision logic. It resolves conditional branches, JAL and JALR in one registered stage and compares the result against the fetch-stage prediction. On a mispredict it issues a one-cycle flush with the correct redirect PC. It also owns a direct-mapped bimodal branch history table (BHT), read by fetch and trained here, plus branch and mispredict event counters. It sits between the issue/execute boundary and the fetch PC mux.

Parameters:
XLEN, 32, datapath and PC width
BHT_ENTRIES, 64, BHT depth; power of two, at least 2; index = pc[log2(BHT_ENTRIES)+1:2]
BHT_INIT, 2'b01, reset value of every 2-bit counter (weakly not-taken)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_valid  in  1  instruction on is_* inputs is valid
i_stall  in  1  downstream stall; no capture, no state change
is_opcode  in  7  instruction opcode
is_func3  in  3  branch condition
is_rs1_data  in  XLEN  forwarded rs1 value
is_rs2_data  in  XLEN  forwarded rs2 value
is_pc  in  XLEN  instruction PC
i_imm  in  XLEN  sign-extended B/J/I immediate
i_pred_taken  in  1  fetch predicted taken
i_pred_pc  in  XLEN  fetch predicted target
i_fetch_pc  in  XLEN  BHT lookup address
o_bht_taken  out  1  combinational: MSB of counter at i_fetch_pc index
o_valid  out  1  resolution result valid (1-cycle pulse)
o_taken  out  1  resolved taken
o_flush  out  1  mispredict flush (1-cycle pulse)
o_redirect_pc  out  XLEN  correct next PC
o_br_count  out  CNT_W  resolved control-transfer count
o_mp_count  out  CNT_W  mispredict count

Behaviour:
- Reset (async, any cycle, including mid-operation): o_valid=0, o_taken=0, o_flush=0, o_redirect_pc=0, both counters=0, all BHT entries=BHT_INIT.
- Capture condition: cap = i_valid & ~i_stall & ~o_flush & is_ctrl.
  - is_ctrl = opcode is BRANCH (1100011), JAL (1101111) or JALR (1100111).
  - While o_flush=1 the incoming instruction is wrong-path and is squashed.
- Latency: 1 cycle. Results register on the clk edge where cap=1. o_valid, o_flush and o_taken are high for exactly that following cycle and 0 otherwise. o_redirect_pc holds its last value.
- Conditions (BRANCH only):
  - BEQ: ==
  - BNE: !=
  - BLT: signed <
  - BGE: signed >=
  - BLTU: unsigned <
  - BGEU: unsigned >=
  - func3 010/011: treated as not-taken; no flush, no BHT update, still counted.
- Targets (modulo 2^XLEN, wrap ignored):
  - BRANCH and JAL: is_pc+i_imm.
  - JALR: (is_rs1_data+i_imm) with bit0 cleared.
  - Fall-through: is_pc+4.
- taken = condition for BRANCH; always 1 for JAL/JALR.
- actual_pc = taken ? target : is_pc+4.
- Mispredict when (taken != i_pred_taken) or (taken & target != i_pred_pc). On mispredict: o_flush=1 and o_redirect_pc=actual_pc. Otherwise o_flush=0.
- BHT training: on cap & BRANCH & valid func3, update the counter at is_pc index on the same edge.
  - Saturating: taken increments, max 3; not-taken decrements, min 0.
  - Jumps do not train.
- BHT read and write at the same index in the same cycle: o_bht_taken returns the pre-update value (no bypass).
- Counters: o_br_count increments on every cap; o_mp_count increments on cap&mispredict. Both wrap from all-ones to 0.
- i_stall=1: no capture, BHT and counters frozen, o_valid/o_flush deassert in the next cycle.

Decomposition:
- parameters.vh (shared): opcode constants BRANCH/JAL/JALR; func3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU; counter state constants SNT/WNT/WT/ST.
- Sub-module bht_bimodal (params BHT_ENTRIES, BHT_INIT). Contents: counter array, async reset, combinational read port, saturating update port.
- The comparator, target logic and mispredict logic stay in branch_resolve_unit.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle o_valid=1, o_taken=1, o_flush=1, o_redirect_pc=0x120; BHT[0x100 index] 01->10; o_mp_count=1.
- BLTU, rs1=rs2=7, pc=0x200, pred_taken=0 -> o_taken=0, o_flush=0; BHT decrements 01->00. Repeating keeps it at 00 (saturation).
- BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=1, pred_pc=pc+imm -> taken, no flush. BGEU with the same operands -> taken; predicted not-taken gives flush.
- JALR, rs1=0x1001, imm=0x4, pred_taken=1, pred_pc=0x1004 -> o_flush=0. With pred_pc=0x1008 -> o_flush=1, o_redirect_pc=0x1004; BHT unchanged.
- Mispredicted branch followed back-to-back by a valid JAL in the flush cycle -> JAL squashed: no o_valid next cycle, o_br_count increases by 1 only.
- i_stall=1 with a valid BNE, then assert rst mid-stream -> no capture while stalled; after rst all outputs and counters are 0 and o_bht_taken=0 for every i_fetch_pc.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit: opcodes, branch conditions,
// bimodal counter states and the saturating counter update.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue-side request, fetch-side BHT lookup and resolution results of the
// branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic            i_valid;
  logic            i_stall;
  logic [6:0]      is_opcode;
  logic [2:0]      is_func3;
  logic [XLEN-1:0] is_rs1_data;
  logic [XLEN-1:0] is_rs2_data;
  logic [XLEN-1:0] is_pc;
  logic [XLEN-1:0] i_imm;
  logic            i_pred_taken;
  logic [XLEN-1:0] i_pred_pc;
  logic [XLEN-1:0] i_fetch_pc;

  logic             o_bht_taken;
  logic             o_valid;
  logic             o_taken;
  logic             o_flush;
  logic [XLEN-1:0]  o_redirect_pc;
  logic [CNT_W-1:0] o_br_count;
  logic [CNT_W-1:0] o_mp_count;

  modport master (
    output i_valid, i_stall, is_opcode, is_func3, is_rs1_data, is_rs2_data,
           is_pc, i_imm, i_pred_taken, i_pred_pc, i_fetch_pc,
    input  o_bht_taken, o_valid, o_taken, o_flush, o_redirect_pc,
           o_br_count, o_mp_count
  );

  modport slave (
    input  i_valid, i_stall, is_opcode, is_func3, is_rs1_data, is_rs2_data,
           is_pc, i_imm, i_pred_taken, i_pred_pc, i_fetch_pc,
    output o_bht_taken, o_valid, o_taken, o_flush, o_redirect_pc,
           o_br_count, o_mp_count
  );
endinterface

// File: rtl/branch_resolve_unit_bht_bimodal.sv
// Direct-mapped table of 2-bit saturating counters with an unbypassed
// combinational read port and a single training port.
module bht_bimodal
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  BHT_INIT    = WNT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
  output logic                           rd_taken_c,
  input  logic                           wr_en,
  input  logic [$clog2(BHT_ENTRIES)-1:0] wr_idx,
  input  logic                           wr_taken
);

  logic [1:0] ctr [BHT_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) ctr[i] <= BHT_INIT;
    end else if (wr_en) begin
      ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
    end
  end

  // Read sees the pre-update value when it collides with a write.
  assign rd_taken_c = ctr[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BRANCH/JAL/JALR in one registered stage, checks the fetch
// prediction, raises a one-cycle flush with redirect and trains the BHT.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [1:0]  BHT_INIT    = WNT,
  parameter int unsigned CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic            is_br, is_jal, is_jalr, is_ctrl;
  logic            f3_ok, cond, taken, mispred, cap, train;
  logic [XLEN-1:0] target, fall_pc, actual_pc;
  logic            unused_fetch_bits;

  // Decode, condition compare, target and mispredict check.
  always_comb begin
    is_br   = (bus.is_opcode == OP_BRANCH);
    is_jal  = (bus.is_opcode == OP_JAL);
    is_jalr = (bus.is_opcode == OP_JALR);
    is_ctrl = is_br | is_jal | is_jalr;
    f3_ok   = 1'b1;
    cond    = 1'b0;
    case (bus.is_func3)
      F3_BEQ:  cond = (bus.is_rs1_data == bus.is_rs2_data);
      F3_BNE:  cond = (bus.is_rs1_data != bus.is_rs2_data);
      F3_BLT:  cond = ($signed(bus.is_rs1_data) <  $signed(bus.is_rs2_data));
      F3_BGE:  cond = ($signed(bus.is_rs1_data) >= $signed(bus.is_rs2_data));
      F3_BLTU: cond = (bus.is_rs1_data <  bus.is_rs2_data);
      F3_BGEU: cond = (bus.is_rs1_data >= bus.is_rs2_data);
      default: f3_ok = 1'b0;
    endcase
    fall_pc   = bus.is_pc + XLEN'(4);
    target    = is_jalr ? ((bus.is_rs1_data + bus.i_imm) & ~XLEN'(1))
                        : (bus.is_pc + bus.i_imm);
    taken     = is_br ? (f3_ok & cond) : 1'b1;
    actual_pc = taken ? target : fall_pc;
    // Reserved branch encodings resolve not-taken and never redirect.
    mispred   = (is_br & ~f3_ok) ? 1'b0
              : ((taken != bus.i_pred_taken) | (taken & (target != bus.i_pred_pc)));
    // The slot right after a flush carries a wrong-path instruction.
    cap       = bus.i_valid & ~bus.i_stall & ~bus.o_flush & is_ctrl;
    train     = cap & is_br & f3_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid       <= 1'b0;
      bus.o_taken       <= 1'b0;
      bus.o_flush       <= 1'b0;
      bus.o_redirect_pc <= '0;
      bus.o_br_count    <= '0;
      bus.o_mp_count    <= '0;
    end else begin
      bus.o_valid <= cap;
      bus.o_taken <= cap & taken;
      bus.o_flush <= cap & mispred;
      if (cap & mispred) bus.o_redirect_pc <= actual_pc;
      if (cap)           bus.o_br_count    <= bus.o_br_count + CNT_W'(1);
      if (cap & mispred) bus.o_mp_count    <= bus.o_mp_count + CNT_W'(1);
    end
  end

  bht_bimodal #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .BHT_INIT    (BHT_INIT)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (bus.i_fetch_pc[IDX_W+1:2]),
    .rd_taken_c (bus.o_bht_taken),
    .wr_en      (train),
    .wr_idx     (bus.is_pc[IDX_W+1:2]),
    .wr_taken   (taken)
  );

  // Only the index field of the fetch address selects a counter.
  assign unused_fetch_bits = ^{bus.i_fetch_pc[XLEN-1:IDX_W+2], bus.i_fetch_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: vector table with scoreboarded results plus hand-written
// squash, no-bypass, stall and reset sequences.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam logic [6:0]  BR    = 7'h63;
  localparam logic [6:0]  JAL   = 7'h6F;
  localparam logic [6:0]  JALR  = 7'h67;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pt;
    logic [31:0] ppc;
    logic        valid, stall;
    logic [31:0] fetch;
    logic        cap, tk, fl;
    logic [31:0] rpc;
    logic        bht;
  } vec_t;

  typedef struct {
    logic        tk;
    logic        fl;
    logic [31:0] rpc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];
  vec_t tbl[25];

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(64), .BHT_INIT(2'b01), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic pt, input logic [31:0] ppc,
                              input logic valid, input logic stall,
                              input logic [31:0] fetch, input logic cap,
                              input logic tk, input logic fl,
                              input logic [31:0] rpc, input logic bht);
    vec_t v;
    v.op = op; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
    v.pt = pt; v.ppc = ppc; v.valid = valid; v.stall = stall; v.fetch = fetch;
    v.cap = cap; v.tk = tk; v.fl = fl; v.rpc = rpc; v.bht = bht;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] fetch, input logic bht);
    return mk(7'h00, 3'd0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, fetch, 1'b0, 1'b0, 1'b0, 0, bht);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive at a negedge; capture is expected on the following posedge.
  task automatic drive(input vec_t v, input int id);
    exp_t e;
    bus.i_valid      = v.valid;
    bus.i_stall      = v.stall;
    bus.is_opcode    = v.op;
    bus.is_func3     = v.f3;
    bus.is_rs1_data  = v.rs1;
    bus.is_rs2_data  = v.rs2;
    bus.is_pc        = v.pc;
    bus.i_imm        = v.imm;
    bus.i_pred_taken = v.pt;
    bus.i_pred_pc    = v.ppc;
    bus.i_fetch_pc   = v.fetch;
    if (v.cap) begin
      e.tk = v.tk; e.fl = v.fl; e.rpc = v.rpc; e.id = id;
      sb.push_back(e);
    end
  endtask

  // Compare the DUT result window against the scoreboard head.
  task automatic collect();
    exp_t e;
    if (bus.o_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_valid: got o_valid=1 expected 0");
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_taken", e.id), 32'(bus.o_taken), 32'(e.tk));
        chk($sformatf("v%0d_flush", e.id), 32'(bus.o_flush), 32'(e.fl));
        if (e.fl) chk($sformatf("v%0d_redirect", e.id), bus.o_redirect_pc, e.rpc);
      end
    end else begin
      chk("idle_flush", 32'(bus.o_flush), 32'd0);
      chk("idle_taken", 32'(bus.o_taken), 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_total++;
        $display("FAIL v%0d_missing_valid: got o_valid=0 expected 1", e.id);
      end
    end
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(BR, 3'd0, 5, 5, 32'h100, 32'h20, 0, 0, 1, 0, 32'h100, 1, 1, 1, 32'h120, 1);
    tbl[1]  = idle(32'h204, 0);
    tbl[2]  = mk(BR, 3'd6, 7, 7, 32'h204, 32'h40, 0, 0, 1, 0, 32'h204, 1, 0, 0, 0, 0);
    tbl[3]  = tbl[2];
    tbl[4]  = mk(BR, 3'd0, 1, 1, 32'h204, 32'h10, 1, 32'h214, 1, 0, 32'h204, 1, 1, 0, 0, 0);
    tbl[5]  = mk(BR, 3'd0, 1, 1, 32'h204, 32'h10, 1, 32'h214, 1, 0, 32'h204, 1, 1, 0, 0, 1);
    tbl[6]  = mk(BR, 3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h80, 1, 32'h380, 1, 0, 32'h300, 1, 1, 0, 0, 1);
    tbl[7]  = mk(BR, 3'd7, 32'hFFFF_FFFF, 1, 32'h308, 32'h80, 0, 0, 1, 0, 32'h308, 1, 1, 1, 32'h388, 1);
    tbl[8]  = idle(32'h008, 1);
    tbl[9]  = mk(JALR, 3'd0, 32'h1001, 0, 32'h40C, 4, 1, 32'h1004, 1, 0, 32'h40C, 1, 1, 0, 0, 0);
    tbl[10] = mk(JALR, 3'd0, 32'h1001, 0, 32'h40C, 4, 1, 32'h1008, 1, 0, 32'h40C, 1, 1, 1, 32'h1004, 0);
    tbl[11] = idle(32'h510, 0);
    tbl[12] = mk(BR, 3'd5, 32'hFFFF_FFFE, 3, 32'h510, 32'h30, 1, 32'h540, 1, 0, 32'h510, 1, 0, 1, 32'h514, 0);
    tbl[13] = idle(32'h010, 0);
    tbl[14] = mk(BR, 3'd2, 0, 0, 32'h604, 32'h10, 1, 32'h614, 1, 0, 32'h604, 1, 0, 0, 0, 1);
    tbl[15] = mk(7'h33, 3'd0, 0, 0, 32'h100, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 0, 1);
    tbl[16] = mk(JAL, 3'd0, 0, 0, 32'h700, 32'hFFFF_FF00, 0, 0, 1, 0, 32'h700, 1, 1, 1, 32'h600, 1);
    tbl[17] = idle(32'h100, 1);
    tbl[18] = mk(BR, 3'd1, 3, 4, 32'h800, 8, 1, 32'h80C, 1, 0, 32'h800, 1, 1, 1, 32'h808, 1);
    tbl[19] = idle(32'h800, 1);
    tbl[20] = mk(BR, 3'd0, 5, 5, 32'h10C, 32'h20, 0, 0, 1, 1, 32'h10C, 0, 0, 0, 0, 0);
    tbl[21] = mk(BR, 3'd0, 5, 5, 32'h100, 32'h20, 1, 32'h120, 1, 0, 32'h100, 1, 1, 0, 0, 1);
    tbl[22] = tbl[21];
    tbl[23] = mk(BR, 3'd1, 5, 5, 32'h100, 32'h20, 0, 0, 1, 0, 32'h100, 1, 0, 0, 0, 1);
    tbl[24] = mk(BR, 3'd1, 5, 5, 32'h100, 32'h20, 0, 0, 1, 0, 32'h100, 1, 0, 0, 0, 0);

    rst = 1'b1;
    drive(idle(32'h100, 0), -1);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_flush", 32'(bus.o_flush), 32'd0);
    chk("rst_redirect", bus.o_redirect_pc, 32'd0);
    chk("rst_br_count", bus.o_br_count, 32'd0);
    chk("rst_bht", 32'(bus.o_bht_taken), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i], i);
      @(negedge clk);
      collect();
      chk($sformatf("v%0d_bht", i), 32'(bus.o_bht_taken), 32'(tbl[i].bht));
    end
    chk("tbl_br_count", bus.o_br_count, 32'd17);
    chk("tbl_mp_count", bus.o_mp_count, 32'd6);

    // Same-index read during training returns the old counter.
    v = mk(BR, 3'd0, 1, 1, 32'h900, 32'h10, 1, 32'h910, 1, 0, 32'h900, 1, 1, 0, 0, 1);
    drive(v, 100);
    #1 chk("bht_pre_update", 32'(bus.o_bht_taken), 32'd0);
    @(negedge clk);
    collect();
    chk("bht_post_update", 32'(bus.o_bht_taken), 32'd1);

    // Jump arriving in the flush cycle is squashed.
    drive(mk(BR, 3'd0, 2, 2, 32'hA00, 32'h40, 0, 0, 1, 0, 32'hA00, 1, 1, 1, 32'hA40, 1), 101);
    @(negedge clk);
    collect();
    drive(mk(JAL, 3'd0, 0, 0, 32'hA04, 32'h100, 0, 0, 1, 0, 32'hA00, 0, 0, 0, 0, 1), 102);
    @(negedge clk);
    collect();
    chk("squash_br_count", bus.o_br_count, 32'd19);
    chk("squash_mp_count", bus.o_mp_count, 32'd7);

    // Stalled branch is held off, then reset lands mid-stream.
    drive(mk(BR, 3'd1, 3, 4, 32'hB00, 8, 0, 0, 1, 1, 32'hB00, 0, 0, 0, 0, 0), 103);
    @(negedge clk);
    collect();
    chk("stall_br_count", bus.o_br_count, 32'd19);
    chk("stall_mp_count", bus.o_mp_count, 32'd7);
    bus.i_stall = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    bus.i_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_taken", 32'(bus.o_taken), 32'd0);
    chk("mid_rst_flush", 32'(bus.o_flush), 32'd0);
    chk("mid_rst_redirect", bus.o_redirect_pc, 32'd0);
    chk("mid_rst_br_count", bus.o_br_count, 32'd0);
    chk("mid_rst_mp_count", bus.o_mp_count, 32'd0);
    for (int i = 0; i < 64; i++) begin
      bus.i_fetch_pc = 32'(i * 4);
      #1 chk($sformatf("rst_bht_%0d", i), 32'(bus.o_bht_taken), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    drive(mk(BR, 3'd0, 1, 1, 32'h104, 32'h20, 0, 0, 1, 0, 32'h104, 1, 1, 1, 32'h124, 1), 104);
    @(negedge clk);
    collect();
    chk("post_rst_bht", 32'(bus.o_bht_taken), 32'd1);
    chk("post_rst_br_count", bus.o_br_count, 32'd1);
    chk("post_rst_mp_count", bus.o_mp_count, 32'd1);
    drive(idle(32'h104, 1), 105);
    @(negedge clk);
    collect();
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
